// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - end-of-program cycle counter and architectural register dump sequencer
module regfile_dump_ctrl #(
  parameter int ARCH_REG_NUM       = 32,
  parameter int ARCH_REG_NUM_WIDTH = 5,
  parameter int REG_VAL_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          finish,
  output logic                          rd_en,
  output logic [ARCH_REG_NUM_WIDTH-1:0] read_red_addr_req,
  input  logic                          read_valid,
  input  logic [REG_VAL_WIDTH-1:0]      read_value,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [ARCH_REG_NUM_WIDTH-1:0] dump_idx,
  output logic [REG_VAL_WIDTH-1:0]      dump_data,
  output logic                          dump_last,
  output logic [31:0]                   cycle_count,
  output logic                          timeout_err,
  output logic                          done
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ARCH_REG_NUM_WIDTH-1:0] LAST_IDX = ARCH_REG_NUM_WIDTH'(ARCH_REG_NUM - 1);
  localparam logic [TMO_W-1:0]              TMO_END  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic                            finish_q;
  logic                            seen_q, seen_d;
  logic [31:0]                     cnt_q, cnt_d;
  logic [ARCH_REG_NUM_WIDTH-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]                tmo_q, tmo_d;
  logic                            rd_en_q, rd_en_d;
  logic [ARCH_REG_NUM_WIDTH-1:0]   addr_q, addr_d;
  logic                            dv_q, dv_d;
  logic [ARCH_REG_NUM_WIDTH-1:0]   didx_q, didx_d;
  logic [REG_VAL_WIDTH-1:0]        ddata_q, ddata_d;
  logic                            dlast_q, dlast_d;
  logic                            terr_q, terr_d;
  logic                            done_q, done_d;
  logic                            finish_edge;

  // Only the first rising sample of finish after reset starts a dump; re-rises are ignored.
  assign finish_edge = finish & ~finish_q & ~seen_q;

  // All state registers, cleared asynchronously so a reset aborts any dump in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      finish_q <= 1'b0;
      seen_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      dv_q     <= 1'b0;
      didx_q   <= '0;
      ddata_q  <= '0;
      dlast_q  <= 1'b0;
      terr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= finish;
      seen_q   <= seen_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      dv_q     <= dv_d;
      didx_q   <= didx_d;
      ddata_q  <= ddata_d;
      dlast_q  <= dlast_d;
      terr_q   <= terr_d;
      done_q   <= done_d;
    end
  end

  // Cycle counter runs until finish is first seen high, saturating instead of wrapping.
  always_comb begin
    seen_d = seen_q | finish_edge;
    cnt_d  = cnt_q;
    if (!finish && !seen_q && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Dump FSM: request a register, wait for data or timeout, hand the beat downstream.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    dv_d    = dv_q;
    didx_d  = didx_q;
    ddata_d = ddata_q;
    dlast_d = dlast_q;
    terr_d  = terr_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (finish_edge) begin
          idx_d   = '0;
          addr_d  = '0;
          rd_en_d = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (read_valid || (tmo_q == TMO_END)) begin
          ddata_d = read_valid ? read_value : '0;
          terr_d  = terr_q | ~read_valid;
          didx_d  = idx_q;
          dlast_d = (idx_q == LAST_IDX);
          dv_d    = 1'b1;
          rd_en_d = 1'b0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (dump_ready) begin
          dv_d = 1'b0;
          if (dlast_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ARCH_REG_NUM_WIDTH'(1);
            addr_d  = idx_q + ARCH_REG_NUM_WIDTH'(1);
            rd_en_d = 1'b1;
            tmo_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      default: begin
        done_d = 1'b1;
      end
    endcase
  end

  assign rd_en             = rd_en_q;
  assign read_red_addr_req = addr_q;
  assign dump_valid        = dv_q;
  assign dump_idx          = didx_q;
  assign dump_data         = ddata_q;
  assign dump_last         = dlast_q;
  assign cycle_count       = cnt_q;
  assign timeout_err       = terr_q;
  assign done              = done_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - randomized scoreboard bench for regfile_dump_ctrl
module tb_regfile_dump_ctrl;
  localparam int N   = 32;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          reset, finish, read_valid, dump_ready;
  logic          rd_en, dump_valid, dump_last, timeout_err, done;
  logic [AW-1:0] read_red_addr_req, dump_idx;
  logic [DW-1:0] read_value, dump_data;
  logic [31:0]   cycle_count;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  regfile_dump_ctrl #(
    .ARCH_REG_NUM(N), .ARCH_REG_NUM_WIDTH(AW), .REG_VAL_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .finish(finish),
    .rd_en(rd_en), .read_red_addr_req(read_red_addr_req),
    .read_valid(read_valid), .read_value(read_value),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
    .cycle_count(cycle_count), .timeout_err(timeout_err), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({rd_en, read_red_addr_req, dump_valid, dump_idx, dump_data,
                              dump_last, timeout_err, done}), 64'd0);
    check({tag, "_cnt"}, 64'(cycle_count), 64'd0);
  endtask

  // One complete dump: finish after fin_delay edges, register model with random
  // latency (silent reg never answers), sink ready with ready_pct percent probability.
  task automatic run(input int fin_delay, input int ready_pct, input int lat_max,
                     input int silent, input bit glitch, input int abort_idx, input bit exact);
    int            cyc, entry, lat, beats;
    bit            prev_rd, prev_dv, prev_rdy, terr_exp;
    logic [AW-1:0] s_idx;
    logic [DW-1:0] s_data, exp_data;
    logic          s_last;

    reset = 1'b1; finish = 1'b0; read_valid = 1'b0; read_value = '0; dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset  = 1'b0;
    finish = (fin_delay == 0);
    if (fin_delay > 0) begin
      repeat (fin_delay) @(posedge clk);
      #1;
      finish = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc = 0; beats = 0; entry = 0; lat = 1;
    prev_rd = 1'b0; prev_dv = 1'b0; prev_rdy = 1'b0; terr_exp = 1'b0;
    s_idx = '0; s_data = '0; s_last = 1'b0;
    check("cnt_at_e0", 64'(cycle_count), 64'(fin_delay));
    check("rd_en_at_e0", 64'(rd_en), 64'd1);

    forever begin
      check("no_overlap", 64'(rd_en & dump_valid), 64'd0);
      if (rd_en) check("rd_addr", 64'(read_red_addr_req), 64'(beats));
      if (rd_en && !prev_rd) begin
        entry = cyc;
        lat   = $urandom_range(1, lat_max);
      end
      if (dump_valid && !prev_dv) begin
        if (beats == silent) begin
          terr_exp = 1'b1;
          check("tmo_latency", 64'(cyc - entry), 64'(TMO));
        end else begin
          check("rd_latency", 64'(cyc - entry), 64'(lat));
        end
      end
      if (prev_dv && !prev_rdy) begin
        check("hold_valid", 64'(dump_valid), 64'd1);
        check("hold_idx", 64'(dump_idx), 64'(s_idx));
        check("hold_data", 64'(dump_data), 64'(s_data));
        check("hold_last", 64'(dump_last), 64'(s_last));
      end
      check("terr", 64'(timeout_err), 64'(terr_exp));
      check("cnt_frozen", 64'(cycle_count), 64'(fin_delay));
      if (done) break;

      if (abort_idx >= 0 && rd_en && (int'(read_red_addr_req) == abort_idx)) begin
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        return;
      end

      if (glitch && cyc == 20) finish = 1'b0;
      if (glitch && cyc == 24) finish = 1'b1;
      dump_ready = ($urandom_range(0, 99) < ready_pct);
      read_value = $urandom;
      read_valid = 1'b0;
      if (rd_en && beats != silent && (cyc + 1 - entry) >= lat) begin
        read_valid = 1'b1;
        read_value = 32'h1000 + beats;
      end else if (glitch && dump_valid) begin
        read_valid = ($urandom_range(0, 1) == 1);
      end

      if (dump_valid && dump_ready) begin
        exp_data = (beats == silent) ? 32'd0 : 32'h1000 + beats;
        check("beat_idx", 64'(dump_idx), 64'(beats));
        check("beat_data", 64'(dump_data), 64'(exp_data));
        check("beat_last", 64'(dump_last), 64'(beats == N - 1));
        beats++;
      end

      prev_rd = rd_en; prev_dv = dump_valid; prev_rdy = dump_ready;
      s_idx = dump_idx; s_data = dump_data; s_last = dump_last;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 6000) begin
        check("cycle_budget", 64'd0, 64'd1);
        break;
      end
    end

    check("beats_total", 64'(beats), 64'(N));
    if (exact) check("done_cycle", 64'(cyc), 64'(2 * N));
    check("terr_end", 64'(timeout_err), 64'(silent >= 0));
    repeat (5) begin
      dump_ready = ($urandom_range(0, 1) == 1);
      read_valid = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      #1;
      check("done_hold", 64'({done, rd_en, dump_valid}), 64'(3'b100));
      check("terr_hold", 64'(timeout_err), 64'(silent >= 0));
      check("cnt_hold", 64'(cycle_count), 64'(fin_delay));
    end
  endtask

  initial begin
    reset = 1'b1; finish = 1'b0; read_valid = 1'b0; read_value = '0; dump_ready = 1'b0;
    run(100, 100, 1, -1, 1'b0, -1, 1'b1);
    run(int'($urandom_range(5, 40)), 30, 4, -1, 1'b0, -1, 1'b0);
    run(0, 70, 2, 7, 1'b0, -1, 1'b0);
    run(20, 50, 3, -1, 1'b0, 12, 1'b0);
    run(17, 60, 3, -1, 1'b1, -1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

End-of-program register-file dump sequencer between the CPU's architectural-register read port and the debug/trace side. Counts clock cycles from reset release until the CPU raises `finish`. It then walks every architectural register through the read handshake and streams each (index, value) pair out on a valid/ready port. This replaces bench-side dump and cycle-count logic with synthesizable hardware.

## Interface
Parameters:
- `ARCH_REG_NUM`, 32: number of architectural registers to dump.
- `ARCH_REG_NUM_WIDTH`, 5: register index width; must satisfy 2^width ≥ ARCH_REG_NUM.
- `REG_VAL_WIDTH`, 32: register value width.
- `TIMEOUT_CYCLES`, 64: maximum number of WAIT cycles allowed per register read.

Ports:
- `clk`  in  1: the block's single clock.
- `reset`  in  1: asynchronous, active-high.
- `finish`  in  1: CPU program-complete indication, level.
- `rd_en`  out  1: register read request.
- `read_red_addr_req`  out  ARCH_REG_NUM_WIDTH: register index being read.
- `read_valid`  in  1: read data valid.
- `read_value`  in  REG_VAL_WIDTH: read data.
- `dump_valid`  out  1: dump beat valid.
- `dump_ready`  in  1: downstream accepts the beat.
- `dump_idx`  out  ARCH_REG_NUM_WIDTH: register index of the current beat.
- `dump_data`  out  REG_VAL_WIDTH: register value of the current beat.
- `dump_last`  out  1: beat is for register ARCH_REG_NUM-1.
- `cycle_count`  out  32: cycles elapsed before `finish`.
- `timeout_err`  out  1: sticky; at least one read timed out.
- `done`  out  1: dump complete.

## Operation
- All outputs are registered.
- Reset value of every output is 0, and the FSM resets to IDLE. Reset asserted at any point aborts the dump immediately, and all state returns to reset values.
- Cycle counter:
  - Increments on every clk edge at which `finish` is sampled low and no finish edge has yet been seen.
  - Freezes permanently, until reset, at the first edge where `finish` is sampled high.
  - Saturates at 0xFFFFFFFF with no wrap.
- Finish detection:
  - A registered `finish_q` is reset to 0. The edge condition is `finish & ~finish_q`.
  - `finish` already high on the first edge after reset counts as an edge.
  - Later drops or re-rises of `finish` are ignored.
- FSM states:
  - IDLE: on a finish edge, set idx=0, `rd_en`<=1, `read_red_addr_req`<=0, clear the timeout counter, and go to WAIT.
  - WAIT: `rd_en` and the address are held stable. On `read_valid`=1:
    - `dump_data`<=`read_value`, `dump_idx`<=idx, `dump_last`<=(idx==ARCH_REG_NUM-1).
    - `dump_valid`<=1, `rd_en`<=0, go to OUT.
  - WAIT timeout: if the timeout counter reaches TIMEOUT_CYCLES with no valid, take the same action with `dump_data`<=0 and set `timeout_err`<=1.
  - OUT: `dump_*` is held stable while `dump_ready`=0. On `dump_ready`=1:
    - `dump_valid`<=0.
    - If last: go to DONE and set `done`<=1.
    - Otherwise: idx++, `rd_en`<=1, address<=idx+1, clear the timeout counter, and go to WAIT directly.
  - DONE: `done` stays 1 and all other requests stay 0 until reset.
- `read_valid` outside WAIT is ignored. `read_value` is sampled only on the accepting edge.
- `dump_ready` outside OUT is ignored.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide. It counts WAIT cycles and is cleared on each WAIT entry.

## Timing
- Finish edge sampled at edge E0 → `rd_en`=1 with address 0 is visible after E0.
- `read_valid` sampled high at edge E1 ≥ E0+1 → `dump_valid` is high after E1.
- `dump_ready` high at edge E2 → the next `rd_en` is high after E2, with no idle cycle between them.
- Minimum cost is 2 cycles per register, so a full dump with zero-latency read and always-ready sink is 2·ARCH_REG_NUM cycles from E0 to the `done` assertion edge.
- Timeout case: the beat is produced at the edge where the WAIT count reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES edges after WAIT entry.
- `cycle_count` equals the number of edges between reset release and the first finish-high sample, excluding that sample edge. It is stable from E0 onward.

## Test plan
- Reset release, `finish` rises after 100 edges → `cycle_count`=100 and stays frozen through and after the dump.
- Reg model returns 0x1000+idx with 1-cycle valid latency, `dump_ready` tied 1:
  - 32 beats, idx 0..31, data 0x1000..0x101F.
  - `dump_last` set only on idx 31.
  - `done` high 64 cycles after E0.
  - `timeout_err`=0.
- `dump_ready` toggled randomly with 30% high → beat order and data are unchanged, `dump_*` are stable while stalled, and `rd_en` never overlaps `dump_valid`.
- Model never answers reg 7 → beat 7 has data 0 and arrives 64 edges after its WAIT entry; `timeout_err`=1 and stays set; regs 8..31 complete normally.
- Reset asserted mid-dump at idx 12 → all outputs are 0 immediately; a new finish edge restarts the dump at idx 0 and the counter restarts from 0.
- `finish` pulses low then high again during the dump, and a stray `read_valid` arrives in OUT → no restart, no extra beat, and data matches the model.
